// File: rtl/timer_pkg.sv
// Shared timer types.
// Exposes timer_state_t so status decode can use it.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: load, load_val, start, stop, auto_reload, tick -> busy, expired, val.
interface countdown_timer_if #(
  parameter int WIDTH = 16
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic             tick;
  logic             busy;
  logic             expired;
  logic [WIDTH-1:0] val;

  modport master (
    output load, load_val, start, stop,
    output auto_reload, tick,
    input  busy, expired, val
  );

  modport slave (
    input  load, load_val, start, stop,
    input  auto_reload, tick,
    output busy, expired, val
  );

endinterface

// File: rtl/countdown_timer.sv
// Down-counting timer, one-shot or periodic, pausable.
// Ports: clk, reset (async active-low), bus (slave: controls in, busy/expired/val out).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  countdown_timer_if.slave  bus
);

  timer_state_t     state, state_nx;
  logic [WIDTH-1:0] count, count_nx;
  logic [WIDTH-1:0] reload, reload_nx;
  logic             expired, expired_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      reload  <= reload_nx;
      expired <= expired_nx;
    end
  end

  // load > stop > start > tick
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    reload_nx  = reload;
    expired_nx = 1'b0;
    if (bus.load) begin
      count_nx  = bus.load_val;
      reload_nx = bus.load_val;
      state_nx  = IDLE;
    end else if (bus.stop) begin
      if (state == RUN)
        state_nx = IDLE;
    end else if (bus.start && state != RUN) begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state_nx = RUN;
          end else begin
            state_nx   = DONE;
            expired_nx = 1'b1;
          end
        end
        DONE: begin
          if (reload != '0) begin
            count_nx = reload;
            state_nx = RUN;
          end else begin
            expired_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state == RUN && bus.tick) begin
      if (count > WIDTH'(1)) begin
        count_nx = count - WIDTH'(1);
      end else if (count == WIDTH'(1)) begin
        expired_nx = 1'b1;
        if (bus.auto_reload && reload != '0) begin
          count_nx = reload;
        end else begin
          count_nx = '0;
          state_nx = DONE;
        end
      end else begin
        // zero count in RUN is unreachable; park safely
        state_nx = DONE;
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.expired = expired;
  assign bus.val     = count;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
// Linear steps with immediate assertions and hand-computed expectations.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  countdown_timer_if #(.WIDTH(16)) bus ();

  countdown_timer #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [15:0] v,
                         input logic b,
                         input logic e);
    chk({tag, ".val"}, 32'(bus.val), 32'(v));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".exp"}, 32'(bus.expired), 32'(e));
  endtask

  initial begin
    int pulses;
    logic [15:0] ev;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.auto_reload = 1'b0;
    bus.tick = 1'b0;
    #12;
    chk_out("rst", 16'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // one-shot
    bus.load = 1'b1;
    bus.load_val = 16'd5;
    cyc();
    chk_out("os_load", 16'd5, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    chk_out("os_start", 16'd5, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.tick = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      cyc();
      chk_out("os_tick", 16'(i), 1'b1, 1'b0);
    end
    cyc();
    chk_out("os_exp", 16'd0, 1'b0, 1'b1);
    cyc();
    chk_out("os_done", 16'd0, 1'b0, 1'b0);
    bus.tick = 1'b0;

    // periodic
    bus.load = 1'b1;
    bus.load_val = 16'd3;
    bus.auto_reload = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    chk_out("per_start", 16'd3, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.tick = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      ev = (i % 3 == 0) ? 16'd3 : 16'(3 - (i % 3));
      chk_out("per", ev, 1'b1, (i % 3 == 0));
      if (bus.expired) pulses++;
    end
    chk("per_pulses", 32'(pulses), 32'd4);
    bus.tick = 1'b0;
    bus.auto_reload = 1'b0;

    // pause / resume
    bus.load = 1'b1;
    bus.load_val = 16'd10;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.tick = 1'b1;
    repeat (4) cyc();
    chk_out("pr_run4", 16'd6, 1'b1, 1'b0);
    bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("pr_stop", 16'd6, 1'b0, 1'b0);
    end
    bus.stop = 1'b0;
    bus.start = 1'b1;
    cyc();
    chk_out("pr_resume", 16'd6, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      cyc();
      chk_out("pr_tick", 16'(i), 1'b1, 1'b0);
    end
    cyc();
    chk_out("pr_exp", 16'd0, 1'b0, 1'b1);
    bus.tick = 1'b0;

    // priority: load beats expiry tick
    bus.load = 1'b1;
    bus.load_val = 16'd2;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.tick = 1'b1;
    cyc();
    chk_out("pri_at1", 16'd1, 1'b1, 1'b0);
    bus.load = 1'b1;
    bus.load_val = 16'd7;
    cyc();
    chk_out("pri_load", 16'd7, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.tick = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.tick = 1'b1;
    repeat (6) cyc();
    chk_out("pri_at1b", 16'd1, 1'b1, 1'b0);
    // stop beats expiry tick
    bus.stop = 1'b1;
    cyc();
    chk_out("pri_stop", 16'd1, 1'b0, 1'b0);
    bus.stop = 1'b0;
    bus.tick = 1'b0;

    // zero-length start from reset
    reset = 1'b0;
    #2;
    reset = 1'b1;
    cyc();
    bus.start = 1'b1;
    cyc();
    chk_out("z_start", 16'd0, 1'b0, 1'b1);
    bus.start = 1'b0;
    cyc();
    chk_out("z_after", 16'd0, 1'b0, 1'b0);
    // restart from DONE
    bus.load = 1'b1;
    bus.load_val = 16'd2;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.tick = 1'b1;
    repeat (2) cyc();
    chk_out("rs_exp1", 16'd0, 1'b0, 1'b1);
    bus.tick = 1'b0;
    bus.start = 1'b1;
    cyc();
    chk_out("rs_restart", 16'd2, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.tick = 1'b1;
    cyc();
    chk_out("rs_t1", 16'd1, 1'b1, 1'b0);
    cyc();
    chk_out("rs_exp2", 16'd0, 1'b0, 1'b1);
    bus.tick = 1'b0;

    // async reset mid-count
    bus.load = 1'b1;
    bus.load_val = 16'd9;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_out("ar_pre", 16'd9, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("ar_async", 16'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    bus.start = 1'b1;
    cyc();
    chk_out("ar_zero", 16'd0, 1'b0, 1'b1);
    bus.start = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer: loads a start value, decrements once per qualified `tick` while running, and raises a single-cycle `expired` pulse when the count reaches zero. It supports one-shot and auto-reload (periodic) operation, pausing, and resuming. It sits in the peripheral/timing layer alongside the up-counting primitives. Its `tick` input is fed by an upstream prescaler, and its `expired` output drives interrupt or timeout logic.

## Interface
- `WIDTH`, default 16: counter and load-value width in bits.

- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `load`, in, 1: load `load_val` into the count and the reload register.
- `load_val`, in, WIDTH: value captured on `load`.
- `start`, in, 1: start or resume counting.
- `stop`, in, 1: pause counting; the count is held.
- `auto_reload`, in, 1: 1 selects periodic mode, 0 selects one-shot. Sampled at the moment of expiry.
- `tick`, in, 1: count enable; one decrement per cycle in which it is high while running.
- `busy`, out, 1: high while in RUN.
- `expired`, out, 1: registered one-cycle pulse on each expiry.
- `val`, out, WIDTH: current count.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **Reset** (asynchronous, `reset`=0) clears:
  - state to IDLE
  - count to 0
  - reload register to 0
  - `expired` to 0
  - `busy` to 0
  - `val` to 0
- **Priority within a cycle:** `load` > `stop` > `start` > `tick`.
- **`load`** (any state):
  - count and reload register both take `load_val`.
  - State becomes IDLE.
  - No expiry and no decrement that cycle.
- **`stop`:**
  - RUN goes to IDLE; the count is held.
  - In IDLE or DONE it has no effect.
- **`start`:**
  - IDLE with count ≠ 0: go to RUN.
  - IDLE with count = 0: go to DONE and pulse `expired`. Zero-length timeout.
  - DONE with reload ≠ 0: count takes the reload value and state goes to RUN. This is a restart.
  - DONE with reload = 0: pulse `expired` again and stay in DONE.
  - RUN: ignored.
- **RUN with `tick`=1:**
  - Count > 1: count decrements by 1.
  - Count = 1: expiry. `expired` pulses, then:
    - If `auto_reload`=1 and reload ≠ 0: count takes the reload value and state stays RUN.
    - Otherwise: count becomes 0 and state goes to DONE.
- **RUN with `tick`=0:** count is held.
- **Arithmetic:** unsigned, WIDTH bits.
  - The count never decrements below 0 and never wraps.
  - A `load_val` of all-ones is legal; it gives 2^WIDTH−1 ticks to expiry.
- **Derived outputs:** `busy` is (state == RUN). `val` is the count register.

## Timing
- **Expiry latency:** `expired` is high for exactly one cycle, in the cycle after the clock edge that samples `tick`=1 with count = 1.
- **Expiry state:** in that same cycle `val` already shows 0 (one-shot) or the reload value (periodic).
- **Ticks to expiry:** N ticks after entering RUN with count N.
- **Continuous tick in periodic mode:** with `tick` held high and reload R, `expired` pulses every R cycles. R=1 gives a pulse every cycle.
- **`load` or `stop` on an expiry tick:** no expiry and no `expired` pulse.
- **`start` after `stop`:** resumes from the held count. No tick is lost or double-counted.
- **Reset mid-RUN:** outputs clear immediately, asynchronously. The first active edge after release sees IDLE.
- **Control pulses:** `start` and `stop` are level-sampled every cycle; a one-cycle pulse is sufficient.

## Structure
- **Shared package `timer_pkg`:** holds `timer_state_t` (enum IDLE/RUN/DONE), so bus-side status registers can decode the state.
- **Sub-modules:** none. Next-state logic, count datapath and reload register are one module. The prescaler driving `tick` lives outside this block.

## Test plan
- **One-shot, basic:** reset, `load` with `load_val`=5, `start`, `tick` held high. Required response:
  - `val` steps 4, 3, 2, 1, 0.
  - `expired` high for exactly one cycle, coinciding with `val`=0.
  - State DONE, `busy`=0.
- **Periodic:** `load_val`=3, `auto_reload`=1, `tick`=1 continuously for 12 cycles after start. Required response:
  - `expired` pulses every 3 cycles, 4 pulses total.
  - `val` cycles 2, 1, 3, 2, 1, 3, …
  - `busy` stays 1.
- **Pause/resume:** `load_val`=10, run for 4 ticks, `stop` for 3 cycles with `tick` high, then `start`. Required response:
  - `val` holds at 6 during the stop.
  - Expiry occurs exactly 6 ticks after resume.
- **Priority collision:** count = 1 in RUN. Drive `tick`+`load`(`load_val`=7) together. Required response: no `expired` pulse, `val`=7, state IDLE. Repeat with `tick`+`stop`: no pulse, `val`=1, state IDLE.
- **Zero and restart:**
  - `start` with count 0 from reset: `expired` pulses once, state DONE.
  - Then `load` 2, `start`, expire, `start` again from DONE: count reloads to 2 and expires after 2 ticks.
- **Async reset:** assert `reset`=0 mid-count, between clock edges, with `val`=9. Required response:
  - `val`, `busy`, `expired` go to 0 without waiting for a clock edge.
  - After release, `start` with count 0 pulses `expired`.
